// File: rtl/cp0_exc_unit_pkg.sv
// -----------------------------------------------------------------------------
// cp0_exc_unit_pkg
//   Shared constants for the coprocessor-0 exception unit and its neighbours in
//   the P7 pipeline: exception codes written into Cause.ExcCode, CP0 register
//   numbers used by mtc0/mfc0, bit positions inside SR/Cause, and the handler
//   entry address that fetch redirects to when Req is asserted.
// -----------------------------------------------------------------------------
package cp0_exc_unit_pkg;

    // Exception codes (Cause.ExcCode)
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // CP0 register numbers
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // Exception handler entry, consumed by the fetch stage
    localparam logic [31:0] HANDLER_ENTRY = 32'h0000_4180;

    // Field positions inside SR and Cause
    localparam int SR_IE_BIT      = 0;
    localparam int SR_EXL_BIT     = 1;
    localparam int IM_IP_LSB      = 10;   // IM (SR) and IP (Cause) share bits 15:10
    localparam int CAUSE_BD_BIT   = 31;
    localparam int EXC_CODE_LSB   = 2;    // Cause.ExcCode occupies bits 6:2

    // Return address for a victim: a delay-slot instruction restarts at its
    // branch, one word earlier. Subtraction wraps at 32 bits.
    function automatic logic [31:0] victim_epc(input logic [31:0] vpc,
                                               input logic        bd);
        return bd ? (vpc - 32'd4) : vpc;
    endfunction

endpackage

// File: rtl/cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// cp0_exc_unit
//   Coprocessor 0 for the P7 MIPS pipeline, placed at M stage. Holds SR, Cause,
//   EPC and PRId, decides whether the M-stage instruction is interrupted or
//   raises an exception, and hands Req/EPC back to the pipeline.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (clears SR, Cause, EPC)
//   en         in   mtc0 write enable
//   CP0Addr    in   [4:0]  register number for mtc0/mfc0
//   CP0In      in   [31:0] mtc0 write data
//   CP0Out     out  [31:0] mfc0 read data (combinational)
//   VPC        in   [31:0] PC of the M-stage (victim) instruction
//   BDIn       in   victim sits in a branch delay slot
//   ExcCodeIn  in   [4:0]  accumulated exception code, 0 = none
//   HWInt      in   [HWINT_W-1:0] level-sensitive interrupt lines
//   EXLClr     in   eret in M stage, clears SR.EXL
//   EPCOut     out  [31:0] current EPC register
//   Req        out  take exception/interrupt this cycle (combinational)
//
// Handshake note: Req is a single-cycle, same-cycle request. There is no ready
// side; the pipeline must flush and redirect whenever Req is high at a clock
// edge, and the unit commits EXL/Cause/EPC on that same edge.
// -----------------------------------------------------------------------------
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2021_0731,
    parameter int          HWINT_W    = 6     // at most 6: lines map to bits 15:10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [4:0]         CP0Addr,
    input  logic [31:0]        CP0In,
    output logic [31:0]        CP0Out,
    input  logic [31:0]        VPC,
    input  logic               BDIn,
    input  logic [4:0]         ExcCodeIn,
    input  logic [HWINT_W-1:0] HWInt,
    input  logic               EXLClr,
    output logic [31:0]        EPCOut,
    output logic               Req
);

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [HWINT_W-1:0] im_q,       im_d;
    logic               exl_q,      exl_d;
    logic               ie_q,       ie_d;
    logic               bd_q,       bd_d;
    logic [HWINT_W-1:0] ip_q,       ip_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [31:0]        epc_q,      epc_d;

    // ------------------------------------------------------------------
    // Request decision
    // ------------------------------------------------------------------
    logic       int_req;
    logic       exc_req;
    logic [4:0] sel_code;

    assign int_req  = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req  = (ExcCodeIn != EXC_INT) & ~exl_q;
    assign Req      = int_req | exc_req;
    // Interrupts outrank the synchronous exception carried by the victim.
    assign sel_code = int_req ? EXC_INT : ExcCodeIn;

    logic wr_sr;
    logic wr_epc;

    // mtc0 only lands when no exception is being taken in the same cycle.
    assign wr_sr  = en & ~Req & (CP0Addr == CP0_SR);
    assign wr_epc = en & ~Req & (CP0Addr == CP0_EPC);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        ip_d       = HWInt;          // IP tracks the lines every cycle

        if (Req) begin
            exl_d      = 1'b1;
            exc_code_d = sel_code;
            bd_d       = BDIn;
            epc_d      = victim_epc(VPC, BDIn);
        end else begin
            if (wr_sr) begin
                im_d  = CP0In[IM_IP_LSB +: HWINT_W];
                exl_d = CP0In[SR_EXL_BIT];
                ie_d  = CP0In[SR_IE_BIT];
            end
            if (wr_epc) begin
                epc_d = CP0In;
            end
            // eret overrides an mtc0 that tries to set EXL in the same cycle.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    logic [31:0] sr_rd;
    logic [31:0] cause_rd;

    always_comb begin
        sr_rd                           = '0;
        sr_rd[IM_IP_LSB +: HWINT_W]     = im_q;
        sr_rd[SR_EXL_BIT]               = exl_q;
        sr_rd[SR_IE_BIT]                = ie_q;

        cause_rd                        = '0;
        cause_rd[CAUSE_BD_BIT]          = bd_q;
        cause_rd[IM_IP_LSB +: HWINT_W]  = ip_q;
        cause_rd[EXC_CODE_LSB +: 5]     = exc_code_q;
    end

    always_comb begin
        CP0Out = '0;
        case (CP0Addr)
            CP0_SR:    CP0Out = sr_rd;
            CP0_CAUSE: CP0Out = cause_rd;
            CP0_EPC:   CP0Out = epc_q;
            CP0_PRID:  CP0Out = PRID_VALUE;
            default:   CP0Out = '0;
        endcase
    end

    assign EPCOut = epc_q;

    // Only some CP0In bits are architecturally writable; the rest are dropped.
    logic unused_cp0in;
    assign unused_cp0in = ^CP0In;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_exc_unit
//   Directed bench for cp0_exc_unit. The driver applies inputs one cycle at a
//   time (just after the rising edge) and pushes the values the outputs must
//   show in that cycle; the monitor samples on the falling edge and pops them.
// -----------------------------------------------------------------------------
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID = 32'h2021_0731;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_in;
  logic [31:0] cp0_out;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic [31:0] epc_out;
  logic        req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cp0_exc_unit #(
    .PRID_VALUE (PRID),
    .HWINT_W    (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Addr   (cp0_addr),
    .CP0In     (cp0_in),
    .CP0Out    (cp0_out),
    .VPC       (vpc),
    .BDIn      (bd_in),
    .ExcCodeIn (exc_code_in),
    .HWInt     (hw_int),
    .EXLClr    (exl_clr),
    .EPCOut    (epc_out),
    .Req       (req)
  );

  // ---------------------------------------------------------------------------
  // scoreboard
  // ---------------------------------------------------------------------------
  localparam int SEL_CP0OUT = 0;
  localparam int SEL_EPC    = 1;
  localparam int SEL_REQ    = 2;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];

  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] a;
      int          s;
      string       n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      case (s)
        SEL_CP0OUT: a = cp0_out;
        SEL_EPC:    a = epc_out;
        default:    a = {31'b0, req};
      endcase
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en          = 1'b0;
    cp0_addr    = 5'd0;
    cp0_in      = 32'h0;
    vpc         = 32'h0;
    bd_in       = 1'b0;
    exc_code_in = 5'd0;
    hw_int      = 6'b0;
    exl_clr     = 1'b0;
  endtask

  task automatic exp_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
    cp0_addr = addr;
    exp_q.push_back(exp);
    sel_q.push_back(SEL_CP0OUT);
    name_q.push_back(name);
  endtask

  task automatic exp_epc(input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    sel_q.push_back(SEL_EPC);
    name_q.push_back(name);
  endtask

  task automatic exp_req(input logic exp, input string name);
    exp_q.push_back({31'b0, exp});
    sel_q.push_back(SEL_REQ);
    name_q.push_back(name);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    en       = 1'b1;
    cp0_addr = addr;
    cp0_in   = data;
  endtask

  task automatic eret_cycle();
    idle();
    exl_clr = 1'b1;
    step();
    exl_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    idle();
    step();
    step();

    // power-on reset state
    exp_read(5'd12, 32'h0, "rst_sr");
    exp_req(1'b0, "rst_req");
    exp_epc(32'h0, "rst_epc");
    step();
    exp_read(5'd13, 32'h0, "rst_cause");
    step();
    exp_read(5'd15, PRID, "rst_prid");
    step();
    reset = 1'b1;
    step();

    // overflow, not in a delay slot
    exc_code_in = 5'd12; vpc = 32'h0000_3010; bd_in = 1'b0;
    exp_req(1'b1, "ov_req");
    step();
    exp_req(1'b0, "ov_exl_masks");
    exp_epc(32'h0000_3010, "ov_epc");
    exp_read(5'd13, 32'h0000_0030, "ov_cause");
    step();
    exp_req(1'b0, "ov_exl_masks2");
    exp_read(5'd12, 32'h0000_0002, "ov_sr_exl");
    step();
    idle();
    exl_clr = 1'b1;
    exp_read(5'd12, 32'h0000_0002, "eret_sr_before");
    step();
    exl_clr = 1'b0;
    exp_read(5'd12, 32'h0000_0000, "eret_sr_after");
    step();

    // AdEL in a delay slot
    exc_code_in = 5'd4; vpc = 32'h0000_3024; bd_in = 1'b1;
    exp_req(1'b1, "bd_req");
    step();
    idle();
    exp_epc(32'h0000_3020, "bd_epc");
    exp_read(5'd13, 32'h8000_0010, "bd_cause");
    step();
    eret_cycle();

    // interrupt outranks AdES
    mtc0(5'd12, 32'h0000_0401);
    exp_req(1'b0, "mtc0_sr_req");
    step();
    idle();
    exp_read(5'd12, 32'h0000_0401, "mtc0_sr_read");
    step();
    hw_int = 6'b000001; exc_code_in = 5'd5; vpc = 32'h0000_3040;
    exp_req(1'b1, "int_req");
    step();
    exc_code_in = 5'd0;
    exp_req(1'b0, "int_exl_masks");
    exp_epc(32'h0000_3040, "int_epc");
    exp_read(5'd13, 32'h0000_0400, "int_cause");
    step();

    // eret with the interrupt still pending re-raises Req
    exl_clr = 1'b1;
    exp_req(1'b0, "eret_pending_req0");
    step();
    exl_clr = 1'b0;
    exp_req(1'b1, "eret_pending_req1");
    exp_read(5'd12, 32'h0000_0401, "eret_pending_sr");
    step();
    eret_cycle();

    // IE=0 masks the interrupt but not the exception
    mtc0(5'd12, 32'h0000_0400);
    step();
    idle();
    hw_int = 6'b000001;
    exp_req(1'b0, "ie0_req");
    exp_read(5'd12, 32'h0000_0400, "ie0_sr");
    step();
    exc_code_in = 5'd5; vpc = 32'h0000_3050;
    exp_req(1'b1, "ie0_exc_req");
    step();
    exc_code_in = 5'd0;
    exp_epc(32'h0000_3050, "ie0_epc");
    exp_read(5'd13, 32'h0000_0414, "ie0_cause");
    step();

    // eret and mtc0 SR.EXL=1 together: eret wins
    idle();
    mtc0(5'd12, 32'h0000_0403);
    exl_clr = 1'b1;
    step();
    idle();
    exp_req(1'b0, "exlclr_win_req");
    exp_read(5'd12, 32'h0000_0401, "exlclr_win_sr");
    step();

    // SR hard-wired zero bits
    mtc0(5'd12, 32'hFFFF_FFFF);
    step();
    idle();
    exp_read(5'd12, 32'h0000_FC03, "sr_mask");
    step();
    eret_cycle();
    mtc0(5'd12, 32'h0000_0000);
    step();
    idle();

    // mtc0 EPC collides with RI: exception wins
    mtc0(5'd14, 32'hDEAD_0000);
    exc_code_in = 5'd10; vpc = 32'h0000_3000; bd_in = 1'b0;
    exp_req(1'b1, "coll_req");
    step();
    idle();
    exp_epc(32'h0000_3000, "coll_epc");
    exp_read(5'd13, 32'h0000_0028, "coll_cause");
    step();
    eret_cycle();

    // plain mtc0 to EPC
    mtc0(5'd14, 32'h1234_5678);
    step();
    idle();
    exp_epc(32'h1234_5678, "mtc0_epc");
    exp_read(5'd14, 32'h1234_5678, "mfc0_epc");
    step();

    // read-only and unmapped registers
    mtc0(5'd13, 32'hFFFF_FFFF);
    step();
    idle();
    exp_read(5'd13, 32'h0000_0028, "cause_ro");
    step();
    mtc0(5'd15, 32'h0000_0000);
    step();
    idle();
    exp_read(5'd15, PRID, "prid_ro");
    step();
    mtc0(5'd3, 32'hA5A5_A5A5);
    step();
    idle();
    exp_read(5'd3, 32'h0000_0000, "unmapped_rd");
    step();

    // syscall at VPC=0 in a delay slot: EPC wraps
    exc_code_in = 5'd8; vpc = 32'h0000_0000; bd_in = 1'b1;
    exp_req(1'b1, "wrap_req");
    step();
    idle();
    exp_epc(32'hFFFF_FFFC, "wrap_epc");
    exp_read(5'd13, 32'h8000_0020, "wrap_cause");
    step();

    // asynchronous reset mid-run with EXL/EPC loaded
    reset = 1'b0;
    exp_epc(32'h0, "arst_epc");
    exp_req(1'b0, "arst_req");
    exp_read(5'd12, 32'h0, "arst_sr");
    step();
    exp_read(5'd13, 32'h0, "arst_cause");
    step();
    exp_read(5'd15, PRID, "arst_prid");
    step();
    reset = 1'b1;
    step();
    step();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expectations unconsumed, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 block for the P7 MIPS pipeline. It consumes the exception flags that E-stage and earlier stages raise (Ov, AdEL, AdES, RI, Syscall) and the external hardware interrupt lines.
- Holds SR, Cause, EPC and PRId. Decides whether to take an exception/interrupt, and returns Req plus EPC to the pipeline.
- Sits at M stage. The pipeline reads Req to flush and redirect fetch to the handler entry. It reads EPCOut to service eret.

Parameters:
PRID_VALUE, 32'h2021_0731, constant returned on reads of register 15.
HWINT_W, 6, number of external interrupt lines (maps to IM/IP bits 15:10).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
en  input  1  mtc0 write enable (M-stage mtc0).
CP0Addr  input  5  register number for mtc0/mfc0.
CP0In  input  32  mtc0 write data.
CP0Out  output  32  mfc0 read data, combinational.
VPC  input  32  PC of the M-stage instruction (the victim).
BDIn  input  1  victim instruction is in a branch delay slot.
ExcCodeIn  input  5  accumulated exception code of the M-stage instruction; 0 means none.
HWInt  input  HWINT_W  external interrupt request lines, level-sensitive.
EXLClr  input  1  eret in M stage; clears EXL.
EPCOut  output  32  current EPC register value.
Req  output  1  take exception/interrupt this cycle, combinational.

Behaviour:
- Reset (reset==0, asynchronous): SR, Cause and EPC clear to 0. Req and CP0Out then follow combinationally from the zero state.
- SR (reg 12): IM = bits 15:10, EXL = bit 1, IE = bit 0. All other bits are hard-wired to 0.
- Cause (reg 13): BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2. All other bits read 0.
- EPC (reg 14) is a full 32-bit register. PRId (reg 15) = PRID_VALUE.
- Any other CP0Addr reads 0, and writes to it are ignored.
- Interrupt request: IntReq = |(HWInt & IM) & IE & ~EXL.
- Exception request: ExcReq = (ExcCodeIn != 0) & ~EXL.
- Req = IntReq | ExcReq, combinational, in the same cycle as the inputs.
- Priority: an interrupt beats a synchronous exception. ExcCode becomes 0 (Int) when IntReq=1, else ExcCodeIn.
- Every rising clk edge, unconditionally: IP <= HWInt.
- Rising clk edge with Req=1:
  - EXL <= 1.
  - ExcCode <= selected code.
  - BD <= BDIn.
  - EPC <= BDIn ? VPC-4 : VPC (32-bit wrap; VPC=0 with BD gives 32'hFFFF_FFFC).
- Rising clk edge with Req=0 and en=1:
  - CP0Addr 12 writes IM, EXL and IE only.
  - CP0Addr 14 writes EPC.
  - Cause and PRId are read-only.
- Req=1 and en=1 in the same cycle: Req wins and the mtc0 write is dropped.
- EXLClr=1 and Req=0: EXL <= 0 at the edge. EXLClr cannot coincide with Req because EXL=1 masks Req.
- mtc0 to SR writing EXL and EXLClr in the same cycle: EXLClr wins (EXL=0).
- Latency:
  - Req is 0-cycle (combinational).
  - Register updates are visible on CP0Out/EPCOut 1 cycle later.
  - No internal bypass from CP0In to CP0Out/EPCOut; stall logic elsewhere covers mtc0-then-eret.
- While EXL=1, all new exceptions and interrupts are ignored: Req=0 and no state change except IP.

Decomposition:
- Shared package: ExcCode constants EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYSCALL=8, EXC_RI=10, EXC_OV=12.
- Shared package: register numbers CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
- Shared package: handler entry 32'h0000_4180, for fetch use.
- No sub-module needed; a single module of roughly 150 lines.

Test Plan:
- Reset: drive reset=0 mid-run after state was loaded → SR=Cause=EPC=0 immediately, CP0Out(15)=32'h2021_0731, Req=0.
- Ov: ExcCodeIn=12, VPC=32'h3010, BDIn=0 → Req=1 same cycle. Next cycle: EPC=32'h3010, Cause=32'h0000_0030, SR.EXL=1, Req=0 even with ExcCodeIn still 12.
- Delay slot: ExcCodeIn=4, VPC=32'h3024, BDIn=1 → next cycle EPC=32'h3020, Cause=32'h8000_0010.
- Interrupt priority:
  - Setup: mtc0 SR=32'h0000_0401, then HWInt=6'b000001 with ExcCodeIn=5 → Req=1.
  - Next cycle: Cause.ExcCode=0, IP bit10=1.
  - Repeat with IE=0 → Req=0.
- eret: with EXL=1, pulse EXLClr → SR.EXL=0 next cycle, and a pending enabled interrupt then raises Req.
- Collision: en=1, CP0Addr=14, CP0In=32'hDEAD_0000 while ExcCodeIn=10, VPC=32'h3000 → EPC=32'h3000; the write is dropped.
